// File: rtl/hazard_controller.sv
// Hazard and sequencing controller for the 16-bit 5-stage CPU: stalls, bubbles,
// IFID flush, EX forward selects and the halt drain, driven by an EX/MEM/WB scoreboard.
module hazard_controller #(
  parameter int NREG         = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [$clog2(NREG)-1:0]  src1_id,
  input  logic [$clog2(NREG)-1:0]  src2_id,
  input  logic                     src1_en,
  input  logic                     src2_en,
  input  logic [$clog2(NREG)-1:0]  dest_id,
  input  logic                     dest_en,
  input  logic                     dest2_en,
  input  logic                     load_id,
  input  logic                     branch_id,
  input  logic                     taken_id,
  input  logic                     halt_id,
  output logic                     stall_pc,
  output logic                     stall_ifid,
  output logic                     bubble_idex,
  output logic                     flush_ifid,
  output logic [1:0]               fwd1_sel,
  output logic [1:0]               fwd2_sel,
  output logic                     halted
);

  localparam int RW = $clog2(NREG);
  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] dest;
    logic          dest_en;
    logic [RW-1:0] dest2;
    logic          dest2_en;
  } sb_entry_t;

  sb_entry_t       ex_reg, mem_reg, ex_next;
  logic            ex_load_reg;
  logic            wb_valid_reg, wb_dest2_en_reg;
  logic [RW-1:0]   wb_dest2_reg;

  logic [1:0]      state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            halted_reg;
  logic [1:0][1:0] fwd_reg, fwd_calc;

  logic [1:0][RW-1:0] src;
  logic [1:0]         src_en;
  logic [1:0]         hz_src;
  logic               hazard, run, advance, halt_acc, stall_all;

  assign src[0]    = src1_id;
  assign src[1]    = src2_id;
  assign src_en[0] = src1_en;
  assign src_en[1] = src2_en;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic act, ex_d, ex_d2, mem_d, mem_d2, wb_d2;
      assign act    = id_valid & src_en[gi];
      assign ex_d   = act & ex_reg.valid  & ex_reg.dest_en   & (ex_reg.dest   == src[gi]);
      assign ex_d2  = act & ex_reg.valid  & ex_reg.dest2_en  & (ex_reg.dest2  == src[gi]);
      assign mem_d  = act & mem_reg.valid & mem_reg.dest_en  & (mem_reg.dest  == src[gi]);
      assign mem_d2 = act & mem_reg.valid & mem_reg.dest2_en & (mem_reg.dest2 == src[gi]);
      assign wb_d2  = act & wb_valid_reg  & wb_dest2_en_reg  & (wb_dest2_reg  == src[gi]);

      assign hz_src[gi] = (ex_d & ex_load_reg) | ex_d2 | mem_d2 |
                          (branch_id & (ex_d | ex_d2 | mem_d | mem_d2));

      // Upper halves bypass the write-through port, so a WB dest2 producer still forwards 11.
      assign fwd_calc[gi] = ex_d            ? 2'b01 :
                            mem_d           ? 2'b10 :
                            (mem_d2 | wb_d2) ? 2'b11 : 2'b00;
    end
  endgenerate

  always_comb begin
    hazard    = |hz_src;
    run       = (state_reg == ST_RUN);
    advance   = run & id_valid & ~hazard & ~rst;
    halt_acc  = advance & halt_id;
    stall_all = run ? hazard : 1'b1;
  end

  assign stall_pc    = stall_all;
  assign stall_ifid  = stall_all;
  assign bubble_idex = stall_all;
  // Halt takes priority over a taken branch in the same cycle.
  assign flush_ifid  = advance & taken_id & ~halt_id;
  assign fwd1_sel    = fwd_reg[0];
  assign fwd2_sel    = fwd_reg[1];
  assign halted      = halted_reg;

  always_comb begin
    ex_next.valid    = advance;
    ex_next.dest     = dest_id;
    ex_next.dest_en  = dest_en;
    ex_next.dest2    = src2_id;
    ex_next.dest2_en = dest2_en;
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_RUN: begin
        if (halt_acc) begin
          state_next = ST_DRAIN;
          cnt_next   = CW'(DRAIN_CYCLES - 1);
        end
      end
      ST_DRAIN: begin
        if (cnt_reg == '0) state_next = ST_HALTED;
        else               cnt_next   = cnt_reg - CW'(1);
      end
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_reg          <= '0;
      mem_reg         <= '0;
      ex_load_reg     <= 1'b0;
      wb_valid_reg    <= 1'b0;
      wb_dest2_en_reg <= 1'b0;
      wb_dest2_reg    <= '0;
      state_reg       <= ST_RUN;
      cnt_reg         <= '0;
      halted_reg      <= 1'b0;
      fwd_reg         <= '0;
    end else begin
      ex_reg          <= ex_next;
      ex_load_reg     <= advance & load_id;
      mem_reg         <= ex_reg;
      wb_valid_reg    <= mem_reg.valid;
      wb_dest2_en_reg <= mem_reg.dest2_en;
      wb_dest2_reg    <= mem_reg.dest2;
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      // One extra edge after entering HALTED lets the WB retirement complete.
      halted_reg      <= (state_reg == ST_HALTED);
      fwd_reg         <= advance ? fwd_calc : '0;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Table-driven bench for hazard_controller: combinational controls checked mid-cycle,
// forward selects checked through a queue one edge after each ID vector.
module tb_hazard_controller;

  logic       clk, rst;
  logic       id_valid, src1_en, src2_en, dest_en, dest2_en, load_id, branch_id, taken_id, halt_id;
  logic [3:0] src1_id, src2_id, dest_id;
  logic       stall_pc, stall_ifid, bubble_idex, flush_ifid, halted;
  logic [1:0] fwd1_sel, fwd2_sel;

  hazard_controller #(.NREG(16), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .src1_id(src1_id), .src2_id(src2_id), .src1_en(src1_en), .src2_en(src2_en),
    .dest_id(dest_id), .dest_en(dest_en), .dest2_en(dest2_en), .load_id(load_id),
    .branch_id(branch_id), .taken_id(taken_id), .halt_id(halt_id),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .bubble_idex(bubble_idex),
    .flush_ifid(flush_ifid), .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic valid; logic [3:0] s1; logic s1en; logic [3:0] s2; logic s2en;
    logic [3:0] d; logic den; logic d2en; logic ld; logic br; logic tk; logic hlt;
    logic e_stall; logic e_flush; logic e_halted; logic [1:0] e_f1; logic [1:0] e_f2;
  } vec_t;

  typedef struct packed { logic [1:0] f1; logic [1:0] f2; } fexp_t;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  vec_t  vecs [28];
  fexp_t fq [$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.valid; src1_id = v.s1; src1_en = v.s1en; src2_id = v.s2; src2_en = v.s2en;
    dest_id = v.d; dest_en = v.den; dest2_en = v.d2en; load_id = v.ld;
    branch_id = v.br; taken_id = v.tk; halt_id = v.hlt;
  endtask

  // Called one time unit after a rising edge; returns one time unit after the next.
  task automatic apply(input vec_t v, input string nm);
    fexp_t e, got_e;
    drive(v);
    #3;
    $display("[TB] %s stall=%b%b%b flush=%b halted=%b", nm, stall_pc, stall_ifid, bubble_idex, flush_ifid, halted);
    chk({nm, " stall"},  {1'b0, stall_pc, stall_ifid, bubble_idex}, {1'b0, {3{v.e_stall}}});
    chk({nm, " flush"},  {3'b0, flush_ifid}, {3'b0, v.e_flush});
    chk({nm, " halted"}, {3'b0, halted},     {3'b0, v.e_halted});
    e.f1 = v.e_f1;
    e.f2 = v.e_f2;
    fq.push_back(e);
    @(posedge clk);
    #1;
    n_tests++;
    if (fq.size() == 0) begin
      n_fail++;
      $display("FAIL %s fwd: scoreboard queue empty", nm);
    end else begin
      e = fq.pop_front();
      got_e.f1 = fwd1_sel;
      got_e.f2 = fwd2_sel;
      if (got_e !== e) begin
        n_fail++;
        $display("FAIL %s fwd: got %b/%b want %b/%b", nm, fwd1_sel, fwd2_sel, e.f1, e.f2);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t h;
    // valid s1 en s2 en d den d2en ld br tk hlt | stall flush halted f1 f2
    vecs[0]  = '{Y,4'd1,Y,4'd2,Y,4'd3,Y,N,N,N,N,N,   N,N,N,2'd0,2'd0}; // ADD R3
    vecs[1]  = '{Y,4'd3,Y,4'd1,Y,4'd7,Y,N,N,N,N,N,   N,N,N,2'd1,2'd0}; // use R3: fwd 01
    vecs[2]  = '{Y,4'd5,Y,4'd0,N,4'd4,Y,N,Y,N,N,N,   N,N,N,2'd0,2'd0}; // LOAD R4
    vecs[3]  = '{Y,4'd6,Y,4'd4,Y,4'd8,Y,N,N,N,N,N,   Y,N,N,2'd0,2'd0}; // SUB R4: load-use
    vecs[4]  = '{Y,4'd6,Y,4'd4,Y,4'd8,Y,N,N,N,N,N,   N,N,N,2'd0,2'd2}; // SUB advances, fwd2 10
    vecs[5]  = '{Y,4'd2,Y,4'd5,Y,4'd2,Y,Y,N,N,N,N,   N,N,N,2'd0,2'd0}; // MUL R2/R5
    vecs[6]  = '{Y,4'd9,Y,4'd5,Y,4'd10,Y,N,N,N,N,N,  Y,N,N,2'd0,2'd0}; // read R5: stall 1
    vecs[7]  = '{Y,4'd9,Y,4'd5,Y,4'd10,Y,N,N,N,N,N,  Y,N,N,2'd0,2'd0}; // stall 2
    vecs[8]  = '{Y,4'd9,Y,4'd5,Y,4'd10,Y,N,N,N,N,N,  N,N,N,2'd0,2'd3}; // fwd2 11
    vecs[9]  = '{Y,4'd1,Y,4'd1,Y,4'd6,Y,N,N,N,N,N,   N,N,N,2'd0,2'd0}; // ADD R6
    vecs[10] = '{Y,4'd6,Y,4'd0,Y,4'd0,N,N,N,Y,Y,N,   Y,N,N,2'd0,2'd0}; // BEQ R6 taken: stall
    vecs[11] = '{Y,4'd6,Y,4'd0,Y,4'd0,N,N,N,Y,Y,N,   Y,N,N,2'd0,2'd0}; // stall 2
    vecs[12] = '{Y,4'd6,Y,4'd0,Y,4'd0,N,N,N,Y,Y,N,   N,Y,N,2'd0,2'd0}; // flush
    vecs[13] = '{Y,4'd6,Y,4'd0,Y,4'd9,Y,N,N,N,N,N,   N,N,N,2'd0,2'd0}; // flush for one cycle only
    vecs[14] = '{Y,4'd1,Y,4'd0,N,4'd11,Y,N,Y,N,N,N,  N,N,N,2'd0,2'd0}; // LOAD R11
    vecs[15] = '{Y,4'd11,N,4'd11,N,4'd12,Y,N,Y,N,N,N,N,N,N,2'd0,2'd0}; // disabled sources
    vecs[16] = '{N,4'd12,Y,4'd12,Y,4'd0,N,N,N,N,N,N, N,N,N,2'd0,2'd0}; // ID bubble
    vecs[17] = '{Y,4'd12,Y,4'd11,Y,4'd14,Y,N,N,N,N,N,N,N,N,2'd2,2'd0}; // MEM fwd, WB none
    vecs[18] = '{Y,4'd1,Y,4'd1,Y,4'd13,Y,N,N,N,N,N,  N,N,N,2'd0,2'd0}; // ADD R13
    vecs[19] = '{Y,4'd1,Y,4'd1,Y,4'd13,Y,N,N,N,N,N,  N,N,N,2'd0,2'd0}; // ADD R13 again
    vecs[20] = '{Y,4'd13,Y,4'd14,Y,4'd15,Y,N,N,N,N,N,N,N,N,2'd1,2'd0}; // nearest wins
    vecs[21] = '{Y,4'd0,N,4'd0,N,4'd0,N,N,N,N,Y,Y,   N,N,N,2'd0,2'd0}; // HALT + taken
    vecs[22] = '{Y,4'd0,N,4'd0,N,4'd0,N,N,N,Y,Y,N,   Y,N,N,2'd0,2'd0}; // drain, no flush
    vecs[23] = '{Y,4'd1,Y,4'd1,Y,4'd2,Y,N,N,N,N,N,   Y,N,N,2'd0,2'd0};
    vecs[24] = '{Y,4'd1,Y,4'd1,Y,4'd2,Y,N,N,N,N,N,   Y,N,N,2'd0,2'd0};
    vecs[25] = '{Y,4'd1,Y,4'd1,Y,4'd2,Y,N,N,N,N,N,   Y,N,N,2'd0,2'd0}; // 3 edges: not yet
    vecs[26] = '{Y,4'd1,Y,4'd1,Y,4'd2,Y,N,N,N,N,N,   Y,N,Y,2'd0,2'd0}; // 4 edges: halted
    vecs[27] = '{Y,4'd1,Y,4'd1,Y,4'd2,Y,N,N,N,N,N,   Y,N,Y,2'd0,2'd0}; // stays halted

    // Reset state, with inputs that would otherwise flush.
    rst = 1'b1;
    h = '{Y,4'd0,N,4'd0,N,4'd0,N,N,N,Y,Y,N, N,N,N,2'd0,2'd0};
    drive(h);
    #12;
    chk("reset stall",  {1'b0, stall_pc, stall_ifid, bubble_idex}, 4'h0);
    chk("reset flush",  {3'b0, flush_ifid}, 4'h0);
    chk("reset halted", {3'b0, halted}, 4'h0);
    chk("reset fwd",    {fwd1_sel, fwd2_sel}, 4'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 28; i++) apply(vecs[i], $sformatf("v%0d", i));

    // Halt behind a load-use stall, then reset in the middle of the drain.
    rst = 1'b1;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    h = '{Y,4'd5,Y,4'd0,N,4'd4,Y,N,Y,N,N,N, N,N,N,2'd0,2'd0}; apply(h, "a_load");
    h = '{Y,4'd4,Y,4'd0,N,4'd0,N,N,N,N,N,Y, Y,N,N,2'd0,2'd0}; apply(h, "a_halt_stalled");
    h = '{Y,4'd4,Y,4'd0,N,4'd0,N,N,N,N,N,Y, N,N,N,2'd2,2'd0}; apply(h, "a_halt_accept");
    h = '{Y,4'd0,N,4'd0,N,4'd0,N,N,N,N,N,N, Y,N,N,2'd0,2'd0}; apply(h, "a_drain");
    #2;
    rst = 1'b1;
    #1;
    chk("mid_drain_rst stall",  {1'b0, stall_pc, stall_ifid, bubble_idex}, 4'h0);
    chk("mid_drain_rst halted", {3'b0, halted}, 4'h0);
    chk("mid_drain_rst fwd",    {fwd1_sel, fwd2_sel}, 4'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    h = '{Y,4'd0,N,4'd0,N,4'd0,N,N,N,Y,Y,N, N,Y,N,2'd0,2'd0}; apply(h, "a_run_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
